// File: rtl/bram_arbiter.sv
// Three-requester arbiter onto a dual-port BRAM: up to two grants per cycle, round-robin scan,
// one-cycle read return via per-port owner tags. Define BRAM_ARB_FIXED_PRIO_EN for fixed m0>m1>m2 order.
module bram_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    input  logic              m2_req,
    input  logic              m2_we,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic [31:0]       m2_wdata,
    output logic              m2_gnt,
    output logic              m2_rvalid,
    output logic [31:0]       m2_rdata,
    output logic              p0_en,
    output logic [ADDR_W-1:0] p0_addr,
    output logic [3:0]        p0_W_req,
    output logic [31:0]       p0_W_data,
    input  logic [31:0]       p0_R_data,
    output logic              p1_en,
    output logic [ADDR_W-1:0] p1_addr,
    output logic [3:0]        p1_W_req,
    output logic [31:0]       p1_W_data,
    input  logic [31:0]       p1_R_data
);

    function automatic logic [1:0] wrap3(input logic [2:0] s);
        logic [2:0] t;
        t = (s >= 3'd3) ? (s - 3'd3) : s;
        return t[1:0];
    endfunction

    logic [2:0]        req;
    logic [2:0]        we;
    logic [ADDR_W-1:0] addr  [3];
    logic [31:0]       wdata [3];
    logic [2:0]        gnt;
    logic [2:0]        rvalid;
    logic [31:0]       rdata [3];
    logic [31:0]       r_data [2];

    logic [1:0]        win_vld;
    logic [1:0]        win_idx [2];
    logic [1:0]        en;
    logic [ADDR_W-1:0] p_addr [2];
    logic [3:0]        w_req  [2];
    logic [31:0]       w_data [2];

    logic [1:0]        tag_vld_q, tag_vld_d;
    logic [1:0]        tag_idx_q [2];
    logic [1:0]        tag_idx_d [2];
    logic [1:0]        start;

    assign req      = {m2_req, m1_req, m0_req};
    assign we       = {m2_we, m1_we, m0_we};
    assign addr[0]  = m0_addr;
    assign addr[1]  = m1_addr;
    assign addr[2]  = m2_addr;
    assign wdata[0] = m0_wdata;
    assign wdata[1] = m1_wdata;
    assign wdata[2] = m2_wdata;
    assign r_data[0] = p0_R_data;
    assign r_data[1] = p1_R_data;

`ifdef BRAM_ARB_FIXED_PRIO_EN
    assign start = 2'd0;
`else
    logic [1:0] rr_ptr_q, rr_ptr_d;
    assign start = rr_ptr_q;

    // Pointer moves past the last requester that actually got a grant.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_vld[1])
            rr_ptr_d = wrap3({1'b0, win_idx[1]} + 3'd1);
        else if (win_vld[0])
            rr_ptr_d = wrap3({1'b0, win_idx[0]} + 3'd1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr_q <= 2'd0;
        else
            rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        logic [1:0] pos;
        win_vld    = 2'b00;
        win_idx[0] = 2'd0;
        win_idx[1] = 2'd0;
        pos        = 2'd0;
        for (int i = 0; i < 3; i++) begin
            pos = wrap3({1'b0, start} + 3'(i));
            if (rst && req[pos]) begin
                if (!win_vld[0]) begin
                    win_vld[0] = 1'b1;
                    win_idx[0] = pos;
                end else if (!win_vld[1]) begin
                    win_vld[1] = 1'b1;
                    win_idx[1] = pos;
                end
            end
        end
        // Two writes to the same word: port 0 wins, the other requester retries.
        if (win_vld[1] && we[win_idx[0]] && we[win_idx[1]] &&
            (addr[win_idx[0]][ADDR_W-1:2] == addr[win_idx[1]][ADDR_W-1:2]))
            win_vld[1] = 1'b0;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic is_wr;
            assign is_wr       = win_vld[gi] && we[win_idx[gi]];
            assign en[gi]      = win_vld[gi];
            assign p_addr[gi]  = win_vld[gi] ? addr[win_idx[gi]] : '0;
            assign w_req[gi]   = is_wr ? 4'hF : 4'h0;
            assign w_data[gi]  = is_wr ? wdata[win_idx[gi]] : '0;
            assign tag_vld_d[gi] = win_vld[gi] && !we[win_idx[gi]];
            assign tag_idx_d[gi] = win_idx[gi];
        end

        for (genvar gi = 0; gi < 3; gi++) begin : g_req
            logic hit0, hit1;
            assign gnt[gi]    = (win_vld[0] && (win_idx[0] == 2'(gi))) ||
                                (win_vld[1] && (win_idx[1] == 2'(gi)));
            assign hit0       = tag_vld_q[0] && (tag_idx_q[0] == 2'(gi));
            assign hit1       = tag_vld_q[1] && (tag_idx_q[1] == 2'(gi));
            assign rvalid[gi] = hit0 || hit1;
            assign rdata[gi]  = hit0 ? r_data[0] : (hit1 ? r_data[1] : 32'h0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld_q    <= 2'b00;
            tag_idx_q[0] <= 2'd0;
            tag_idx_q[1] <= 2'd0;
        end else begin
            tag_vld_q    <= tag_vld_d;
            tag_idx_q[0] <= tag_idx_d[0];
            tag_idx_q[1] <= tag_idx_d[1];
        end
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m2_gnt    = gnt[2];
    assign m0_rvalid = rvalid[0];
    assign m1_rvalid = rvalid[1];
    assign m2_rvalid = rvalid[2];
    assign m0_rdata  = rdata[0];
    assign m1_rdata  = rdata[1];
    assign m2_rdata  = rdata[2];

    assign p0_en     = en[0];
    assign p0_addr   = p_addr[0];
    assign p0_W_req  = w_req[0];
    assign p0_W_data = w_data[0];
    assign p1_en     = en[1];
    assign p1_addr   = p_addr[1];
    assign p1_W_req  = w_req[1];
    assign p1_W_data = w_data[1];

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural dual-port BRAM (registered, read-before-write).
// Build with BRAM_ARB_FIXED_PRIO_EN defined to exercise the fixed-priority variant instead.
module tb_bram_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m1_req, m2_req;
    logic        m0_we, m1_we, m2_we;
    logic [31:0] m0_addr, m1_addr, m2_addr;
    logic [31:0] m0_wdata, m1_wdata, m2_wdata;
    logic        m0_gnt, m1_gnt, m2_gnt;
    logic        m0_rvalid, m1_rvalid, m2_rvalid;
    logic [31:0] m0_rdata, m1_rdata, m2_rdata;
    logic        p0_en, p1_en;
    logic [31:0] p0_addr, p1_addr;
    logic [3:0]  p0_W_req, p1_W_req;
    logic [31:0] p0_W_data, p1_W_data;
    logic [31:0] p0_R_data, p1_R_data;

    logic [31:0] mem [256];
    int          n_chk;
    int          n_fail;

    bram_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m2_req(m2_req), .m2_we(m2_we), .m2_addr(m2_addr), .m2_wdata(m2_wdata),
        .m2_gnt(m2_gnt), .m2_rvalid(m2_rvalid), .m2_rdata(m2_rdata),
        .p0_en(p0_en), .p0_addr(p0_addr), .p0_W_req(p0_W_req), .p0_W_data(p0_W_data),
        .p0_R_data(p0_R_data),
        .p1_en(p1_en), .p1_addr(p1_addr), .p1_W_req(p1_W_req), .p1_W_data(p1_W_data),
        .p1_R_data(p1_R_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Both ports sample the old contents on the edge that writes, giving read-before-write.
    always @(posedge clk) begin
        if (p0_en) begin
            p0_R_data <= mem[p0_addr[9:2]];
            if (p0_W_req == 4'hF) mem[p0_addr[9:2]] <= p0_W_data;
        end
        if (p1_en) begin
            p1_R_data <= mem[p1_addr[9:2]];
            if (p1_W_req == 4'hF) mem[p1_addr[9:2]] <= p1_W_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic setm(input int n, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
        case (n)
            0: begin m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; end
            1: begin m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; end
            default: begin m2_req = r; m2_we = w; m2_addr = a; m2_wdata = d; end
        endcase
    endtask

    task automatic idle_all();
        for (int n = 0; n < 3; n++) setm(n, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic read_all();
        setm(0, 1'b1, 1'b0, 32'h10, 32'h0);
        setm(1, 1'b1, 1'b0, 32'h20, 32'h0);
        setm(2, 1'b1, 1'b0, 32'h30, 32'h0);
    endtask

    initial begin
        logic [2:0] pat [3];
        logic [2:0] g;
        logic [2:0] rv;
        int         cnt [3];
        int         wt [3];
        int         maxw;

        n_chk  = 0;
        n_fail = 0;
        p0_R_data = 32'h0;
        p1_R_data = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]  = 32'h1111_0010;
        mem[8]  = 32'h2222_0020;
        mem[12] = 32'h3333_0030;

        rst = 1'b0;
        read_all();
        repeat (2) @(negedge clk);
        #1;
        $display("txn: reset with all requests active");
        chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rst_m2_gnt", 32'(m2_gnt), 32'h0);
        chk("rst_p0_en", 32'(p0_en), 32'h0);
        chk("rst_p1_en", 32'(p1_en), 32'h0);
        chk("rst_rvalid", 32'({m2_rvalid, m1_rvalid, m0_rvalid}), 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);

`ifdef BRAM_ARB_FIXED_PRIO_EN
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            $display("txn: fixed-prio cycle %0d gnt=%b%b%b", c, m2_gnt, m1_gnt, m0_gnt);
            chk("fx_m0_gnt", 32'(m0_gnt), 32'h1);
            chk("fx_m1_gnt", 32'(m1_gnt), 32'h1);
            chk("fx_m2_gnt", 32'(m2_gnt), 32'h0);
        end
        @(negedge clk); idle_all(); #1;
        chk("fx_m0_rvalid", 32'(m0_rvalid), 32'h1);
        chk("fx_m0_rdata", m0_rdata, 32'h1111_0010);
`else
        // Three simultaneous reads right after reset.
        @(negedge clk); rst = 1'b1; #1;
        $display("txn: three reads after reset");
        chk("r3_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("r3_m1_gnt", 32'(m1_gnt), 32'h1);
        chk("r3_m2_gnt", 32'(m2_gnt), 32'h0);
        chk("r3_p0_addr", p0_addr, 32'h10);
        chk("r3_p1_addr", p1_addr, 32'h20);
        chk("r3_p0_wreq", 32'(p0_W_req), 32'h0);
        @(negedge clk);
        setm(0, 1'b0, 1'b0, 32'h0, 32'h0);
        setm(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        $display("txn: read return m0/m1, m2 grant");
        chk("r3_m0_rvalid", 32'(m0_rvalid), 32'h1);
        chk("r3_m0_rdata", m0_rdata, 32'h1111_0010);
        chk("r3_m1_rvalid", 32'(m1_rvalid), 32'h1);
        chk("r3_m1_rdata", m1_rdata, 32'h2222_0020);
        chk("r3_m2_gnt2", 32'(m2_gnt), 32'h1);
        chk("r3_m2_on_p0", p0_addr, 32'h30);
        chk("r3_p1_idle", 32'(p1_en), 32'h0);
        chk("r3_p1_addr0", p1_addr, 32'h0);
        @(negedge clk); idle_all(); #1;
        $display("txn: read return m2");
        chk("r3_m2_rvalid", 32'(m2_rvalid), 32'h1);
        chk("r3_m2_rdata", m2_rdata, 32'h3333_0030);
        chk("r3_m0_rv_off", 32'(m0_rvalid), 32'h0);
        chk("r3_m0_rdata0", m0_rdata, 32'h0);

        // Write-write conflict on word 0x10 (byte 0x40 vs 0x43).
        @(negedge clk);
        setm(0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        setm(1, 1'b1, 1'b1, 32'h43, 32'h1234_5678);
        #1;
        $display("txn: write-write conflict");
        chk("ww_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("ww_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("ww_p1_en", 32'(p1_en), 32'h0);
        chk("ww_p0_wreq", 32'(p0_W_req), 32'hF);
        chk("ww_p0_wdata", p0_W_data, 32'hDEAD_BEEF);
        @(negedge clk); setm(0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
        chk("ww_m1_gnt2", 32'(m1_gnt), 32'h1);
        chk("ww_m1_addr", p0_addr, 32'h43);
        chk("ww_m1_wdata", p0_W_data, 32'h1234_5678);
        chk("ww_no_rvalid", 32'(m0_rvalid), 32'h0);
        @(negedge clk); idle_all(); setm(0, 1'b1, 1'b0, 32'h40, 32'h0); #1;
        chk("ww_rd_gnt", 32'(m0_gnt), 32'h1);
        @(negedge clk); idle_all(); #1;
        $display("txn: read back word 0x10");
        chk("ww_rd_rvalid", 32'(m0_rvalid), 32'h1);
        chk("ww_final", m0_rdata, 32'h1234_5678);

        // Read and write to the same word in one cycle.
        @(negedge clk);
        setm(0, 1'b1, 1'b1, 32'h80, 32'hA5A5_A5A5);
        setm(1, 1'b1, 1'b0, 32'h80, 32'h0);
        #1;
        $display("txn: read/write same word");
        chk("rw_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("rw_m1_gnt", 32'(m1_gnt), 32'h1);
        chk("rw_p0_rd", 32'(p0_W_req), 32'h0);
        chk("rw_p1_wr", 32'(p1_W_req), 32'hF);
        chk("rw_p1_addr", p1_addr, 32'h80);
        @(negedge clk); idle_all(); #1;
        chk("rw_m1_rvalid", 32'(m1_rvalid), 32'h1);
        chk("rw_m1_old", m1_rdata, 32'h0);
        chk("rw_m0_rvalid", 32'(m0_rvalid), 32'h0);
        @(negedge clk); setm(2, 1'b1, 1'b0, 32'h80, 32'h0); #1;
        chk("rw_m2_gnt", 32'(m2_gnt), 32'h1);
        @(negedge clk); idle_all(); #1;
        chk("rw_m2_new", m2_rdata, 32'hA5A5_A5A5);

        // Six cycles of continuous reads from all three requesters.
        pat[0] = 3'b011; pat[1] = 3'b101; pat[2] = 3'b110;
        for (int n = 0; n < 3; n++) begin cnt[n] = 0; wt[n] = 0; end
        maxw = 0;
        @(negedge clk); read_all();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            g  = {m2_gnt, m1_gnt, m0_gnt};
            rv = {m2_rvalid, m1_rvalid, m0_rvalid};
            $display("txn: rr cycle %0d gnt=%b rvalid=%b", c, g, rv);
            chk("rr_gnt", 32'(g), 32'(pat[c % 3]));
            chk("rr_rvalid", 32'(rv), (c == 0) ? 32'h0 : 32'(pat[(c + 2) % 3]));
            for (int n = 0; n < 3; n++) begin
                if (g[n]) begin cnt[n]++; wt[n] = 0; end
                else begin wt[n]++; if (wt[n] > maxw) maxw = wt[n]; end
            end
        end
        @(negedge clk); idle_all(); #1;
        chk("rr_cnt0", 32'(cnt[0]), 32'd4);
        chk("rr_cnt1", 32'(cnt[1]), 32'd4);
        chk("rr_cnt2", 32'(cnt[2]), 32'd4);
        chk("rr_maxwait_le2", 32'(maxw <= 2), 32'h1);

        // Reset asserted the cycle after an m2 read grant, with rr_ptr left at 1.
        @(negedge clk); setm(0, 1'b1, 1'b0, 32'h10, 32'h0); #1;
        chk("ra_m0_gnt", 32'(m0_gnt), 32'h1);
        @(negedge clk); setm(2, 1'b1, 1'b0, 32'h30, 32'h0); #1;
        $display("txn: m2 read grant before reset");
        chk("ra_m2_gnt", 32'(m2_gnt), 32'h1);
        chk("ra_m2_on_p0", p0_addr, 32'h30);
        @(negedge clk); rst = 1'b0; idle_all(); #1;
        chk("ra_m2_rv_rst", 32'(m2_rvalid), 32'h0);
        chk("ra_m2_rd_rst", m2_rdata, 32'h0);
        chk("ra_m0_rv_rst", 32'(m0_rvalid), 32'h0);
        @(negedge clk); #1;
        chk("ra_m2_rv_rst2", 32'(m2_rvalid), 32'h0);
        @(negedge clk); rst = 1'b1; read_all(); #1;
        $display("txn: three reads after reset release");
        chk("ra_m2_rv_rel", 32'(m2_rvalid), 32'h0);
        chk("ra_ptr0_m0", 32'(m0_gnt), 32'h1);
        chk("ra_ptr0_m1", 32'(m1_gnt), 32'h1);
        chk("ra_ptr0_m2", 32'(m2_gnt), 32'h0);
        @(negedge clk); idle_all(); #1;
        chk("ra_m0_rvalid", 32'(m0_rvalid), 32'h1);
        chk("ra_m0_rdata", m0_rdata, 32'h1111_0010);
        chk("ra_m2_rv_off", 32'(m2_rvalid), 32'h0);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width of requester and port addresses.
REQ-002 The block SHALL use reset rst, asynchronous, active-low, and clock clk.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 mN_req  input  1  requester N (N=0..2) access request; m0=DMA loader, m1=PE reader, m2=host.
REQ-006 mN_we  input  1  1=full-word write, 0=read.
REQ-007 mN_addr  input  ADDR_W  byte address; word index = addr>>2.
REQ-008 mN_wdata  input  32  write data.
REQ-009 mN_gnt  output  1  request accepted this cycle.
REQ-010 mN_rvalid  output  1  read data valid for requester N.
REQ-011 mN_rdata  output  32  read data.
REQ-012 pK_en  output  1  BRAM port K (K=0,1) enable.
REQ-013 pK_addr  output  ADDR_W  BRAM port K byte address.
REQ-014 pK_W_req  output  4  4'b1111 on write, 4'b0000 on read.
REQ-015 pK_W_data  output  32  BRAM port K write data.
REQ-016 pK_R_data  input  32  BRAM port K read data, registered, valid one cycle after enable.

Function
REQ-017 Each cycle the block SHALL grant at most two requesters: first winner on port 0, second on port 1.
REQ-018 Winners SHALL be chosen by scanning requesters in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3), taking the first two with req=1.
REQ-019 mN_gnt, pK_en, pK_addr, pK_W_req and pK_W_data SHALL be combinational from the current requests and rr_ptr; a request is consumed only in the cycle gnt=1.
REQ-020 Unused port: pK_en=0, pK_W_req=0, pK_addr=0, pK_W_data=0.
REQ-021 Write-write conflict: if both winners are writes with equal addr[ADDR_W-1:2], only the port-0 winner SHALL be granted; the other waits.
REQ-022 Read and write to the same word in one cycle SHALL both be granted; the read returns the pre-write data.
REQ-023 A registered owner tag per port SHALL record the granted read requester; tag is cleared on writes and idle cycles.
REQ-024 One cycle after a read grant on port K, the owning requester's mN_rvalid SHALL be 1 for exactly one cycle and mN_rdata SHALL equal pK_R_data.
REQ-025 mN_rdata SHALL be 0 when mN_rvalid=0.
REQ-026 Read latency is one cycle; back-to-back reads by one requester SHALL sustain one read per cycle.
REQ-027 After any cycle with at least one grant, rr_ptr SHALL become (index of the last granted requester + 1) mod 3; with no grant, rr_ptr holds.
REQ-028 A requester with req held continuously SHALL be granted within 2 cycles (no starvation).

Reset
REQ-029 On rst=0: rr_ptr=0, both owner tags cleared, all mN_rvalid=0, mN_rdata=0.
REQ-030 A read granted in the cycle before reset assertion SHALL NOT produce rvalid after reset release.
REQ-031 While rst=0, all mN_gnt and pK_en SHALL be 0.

Configuration
REQ-032 Macro BRAM_ARB_FIXED_PRIO_EN: when defined, scan order is fixed m0, m1, m2 and rr_ptr is not implemented; when undefined, round-robin per REQ-018/REQ-027 applies.

Verification
REQ-033 All three read at 0x10, 0x20, 0x30 after reset -> m0 on p0, m1 on p1, m2 gnt=0; next cycle m0/m1 rvalid=1 with the stored data; m2 granted on p0.
REQ-034 m0 writes 0xDEADBEEF to 0x40 while m1 writes 0x12345678 to 0x43 -> only m0 granted; m1 granted next cycle; final word 0x10 = 0x12345678.
REQ-035 m0 writes 0xA5A5A5A5 to 0x80 while m1 reads 0x80 (old value 0x0) -> both granted; m1_rvalid next cycle with rdata 0x0.
REQ-036 All three hold reads for 6 cycles -> each requester granted 4 times; no requester waits more than 2 cycles.
REQ-037 Assert rst one cycle after an m2 read grant -> m2_rvalid stays 0, rr_ptr=0 after release.
REQ-038 With BRAM_ARB_FIXED_PRIO_EN, all three hold reads for 4 cycles -> m2_gnt stays 0 throughout.
